led_flow_ctrl: RTL
==================

# led_flow_ctrl

Parametrised LED running-light controller. It drives `LED_NUM` LEDs from one clock. A programmable prescaler sets the step rate, and a run-time mode input selects rotate-left, rotate-right, ping-pong or bar-fill patterns. It sits between the board clock and the LED pins and replaces the fixed-width, fixed-rate running light used on earlier boards.

## Interface
Parameters:
- `LED_NUM`, default 8: number of LEDs. Legal values are 2 or more.
- `CNT_W`, default 26: width of the prescaler counter and of `period`.
- `ACTIVE_LOW`, default 0: when 1, `led` is driven inverted for boards with common-anode LEDs.

Ports:
- `clk`, input, 1: system clock. Everything is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en`, input, 1: run enable. Low freezes the prescaler and the pattern.
- `mode`, input, 2: pattern select. 0 = rotate left, 1 = rotate right, 2 = ping-pong, 3 = bar fill.
- `period`, input, CNT_W: step interval in clock cycles. A value of 0 is treated as 1.
- `led`, output, LED_NUM: LED drive, registered.
- `step_pulse`, output, 1: high for one cycle in each cycle in which `led` has just changed.
- `dir`, output, 1: ping-pong direction. 0 = toward MSB, 1 = toward LSB.

## Operation
Internal state:
- `pat[LED_NUM-1:0]`: logical pattern. `led = ACTIVE_LOW ? ~pat : pat`.
- `cnt`: prescaler counter.
- `mode_q`: registered copy of `mode`.
- `dir`: ping-pong direction.

Reset (async, while `rst_n` = 0):
- `pat` = 1 (bit 0 lit), `cnt` = 0, `mode_q` = 0, `dir` = 0, `step_pulse` = 0.
- `led` = 1, or ~1 when `ACTIVE_LOW` = 1.

Prescaler:
- `P = (period == 0) ? 1 : period`.
- When `en` = 1 and `cnt >= P-1`, a tick occurs: `cnt` <= 0.
- When `en` = 1 and no tick occurs, `cnt` <= `cnt`+1.
- When `en` = 0, `cnt` holds.
- Because the compare is `>=`, reducing `period` below the current `cnt` ticks on the next cycle rather than wrapping.

Mode change:
- If `mode` != `mode_q`, that cycle is a reload: `mode_q` <= `mode`, `cnt` <= 0, `dir` <= 0, and `step_pulse` <= 0.
- `pat` is loaded with the start pattern for the new mode:
  - mode 0 and mode 2: 1.
  - mode 1: 1<<(LED_NUM-1).
  - mode 3: 0.
- A reload takes priority over a tick and happens even when `en` = 0.

Step on a tick (no reload in the same cycle): `step_pulse` <= 1, and `pat` advances according to `mode_q`:
- Mode 0: rotate left; the MSB wraps to bit 0.
- Mode 1: rotate right; bit 0 wraps to the MSB.
- Mode 2 (ping-pong):
  - If `dir` = 0 and the MSB is set: shift right and set `dir` <= 1.
  - If `dir` = 0 otherwise: shift left.
  - If `dir` = 1 and bit 0 is set: shift left and set `dir` <= 0.
  - If `dir` = 1 otherwise: shift right.
  - End LEDs are never repeated, so a full cycle is 2·LED_NUM−2 steps.
- Mode 3 (bar fill):
  - If `pat` is all ones: `pat` <= 0.
  - Otherwise: `pat` <= {pat[LED_NUM-2:0], 1'b1}.
  - A full cycle is LED_NUM+1 steps.

Other rules:
- In modes 0, 1 and 3, `dir` holds its value.
- `step_pulse` is 0 in every cycle that is not a step.
- `pat` can never become all zeros in modes 0–2. No error state exists.

## Timing
- Every output is a flop output; there is no combinational path from input to output.
- With `en` held at 1 and a constant P, `led` changes exactly every P clocks, and `step_pulse` pulses in the same cycle as each change.
- After reset release with `en` = 1, `mode` = 0 and no reload, the first step lands on the P-th rising edge.
- After a reload, the first step lands P edges later.
- `en` falling mid-count: `cnt` freezes. When `en` returns, the count resumes from the frozen value, so the remaining cycles are preserved.
- `mode` and `period` are sampled every cycle. They are synchronous inputs; synchronising them is the integrator's responsibility.
- Asserting `rst_n` mid-step returns all state to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset with LED_NUM=8, period=4, mode=0, en=1 -> led steps 0x01→0x02→…→0x80→0x01; each change is 4 clocks apart; step_pulse is high exactly in the change cycles.
- Mode=2 with period=1 -> led sequence 01,02,04,…,80,40,…,02,01,02 (a 14-step cycle); dir goes to 1 in the cycle led becomes 0x40 and back to 0 in the cycle led becomes 0x02.
- Mode=3 with period=2 -> 00,01,03,07,…,FF,00; 9 steps per cycle.
- Mid-count, set en=0 for 10 cycles, then switch mode from 0 to 1 while en=0 -> led holds until the reload, then becomes 0x80 with cnt=0 and no step_pulse; after en=1 the next step occurs P clocks later and gives 0x40.
- Reduce period from 100 to 3 while cnt=50 -> a tick occurs on the next clock; after that, steps are every 3 clocks. Also check period=0, which must step every clock.
- ACTIVE_LOW=1 build, with rst_n asserted asynchronously between clock edges -> led goes to 0xFE without waiting for a clock edge; step_pulse=0 and dir=0.

Source files
------------

// File: rtl/led_flow_ctrl.sv
// Parametrised LED running-light controller: prescaled step tick driving
// rotate-left, rotate-right, ping-pong and bar-fill patterns.
module led_flow_ctrl #(
  parameter int LED_NUM    = 8,
  parameter int CNT_W      = 26,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse,
  output logic               dir
);

  // mode      | meaning
  // MODE_ROTL | rotate left, MSB wraps to bit 0
  // MODE_ROTR | rotate right, bit 0 wraps to MSB
  // MODE_PING | ping-pong, direction held in dir
  // MODE_BAR  | bar fill, clears after all ones
  typedef enum logic [1:0] {
    MODE_ROTL = 2'd0,
    MODE_ROTR = 2'd1,
    MODE_PING = 2'd2,
    MODE_BAR  = 2'd3
  } mode_e;

  localparam logic [LED_NUM-1:0] PAT_LSB = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] PAT_MSB = {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] LED_RST = ACTIVE_LOW ? ~PAT_LSB : PAT_LSB;

  logic [LED_NUM-1:0] pat_q, pat_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mode_e              mode_q, mode_d;
  logic               dir_q, dir_d;
  logic               step_q, step_d;

  logic [CNT_W-1:0]   per_eff;
  logic               tick;
  logic               reload;
  logic [LED_NUM-1:0] shl, shr;

  always_comb begin
    per_eff = (period == '0) ? CNT_W'(1) : period;
    // >= rather than == so a shrinking period ticks at once instead of wrapping
    tick    = en && (cnt_q >= (per_eff - CNT_W'(1)));
    reload  = (mode_e'(mode) != mode_q);
    shl     = {pat_q[LED_NUM-2:0], 1'b0};
    shr     = {1'b0, pat_q[LED_NUM-1:1]};

    pat_d   = pat_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    step_d  = 1'b0;

    if (reload) begin
      mode_d = mode_e'(mode);
      cnt_d  = '0;
      dir_d  = 1'b0;
      case (mode_e'(mode))
        MODE_ROTR: pat_d = PAT_MSB;
        MODE_BAR:  pat_d = '0;
        default:   pat_d = PAT_LSB;
      endcase
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode_q)
        MODE_ROTL: pat_d = {pat_q[LED_NUM-2:0], pat_q[LED_NUM-1]};
        MODE_ROTR: pat_d = {pat_q[0], pat_q[LED_NUM-1:1]};
        MODE_PING: begin
          if (!dir_q) begin
            if (pat_q[LED_NUM-1]) begin
              pat_d = shr;
              dir_d = 1'b1;
            end else begin
              pat_d = shl;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d = shl;
              dir_d = 1'b0;
            end else begin
              pat_d = shr;
            end
          end
        end
        default: pat_d = (&pat_q) ? '0 : {pat_q[LED_NUM-2:0], 1'b1};
      endcase
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    led_d = ACTIVE_LOW ? ~pat_d : pat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PAT_LSB;
      led_q  <= LED_RST;
      cnt_q  <= '0;
      mode_q <= MODE_ROTL;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      led_q  <= led_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_q;
  assign dir        = dir_q;

endmodule
